// File: rtl/alu_exec_stage.sv
// Execute-stage ALU with a registered result/branch flag/tag and valid/ready on both sides.
// Define SERIAL_SHIFT_EN to run SLL/SRL/SRA one bit per cycle instead of a barrel shifter.
module alu_exec_stage #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            Operation,
   input  logic [DATA_WIDTH-1:0] SrcA,
   input  logic [DATA_WIDTH-1:0] SrcB,
   input  logic [4:0]            rd_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] ALUResult,
   output logic                  Zero,
   output logic [4:0]            rd_out
);

   // Handshake: a request moves on an edge where in_valid && in_ready; a result
   // moves on an edge where out_valid && out_ready. Held outputs never change while stalled.
`ifdef SERIAL_SHIFT_EN
   typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`else
   typedef enum logic [0:0] {IDLE} state_t;
`endif

   state_t                state_q, state_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic                  zero_q, zero_d;
   logic [4:0]            rd_q, rd_d;

   logic [DATA_WIDTH-1:0] alu_res;
   logic                  alu_zero;
   logic [DATA_WIDTH-1:0] diff;
   logic                  lt;
   logic [4:0]            shamt;
   logic                  out_free;
   logic                  in_ready_int;
   logic                  accept;

`ifdef SERIAL_SHIFT_EN
   logic                  is_shift;
   logic [4:0]            cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d;
   logic [1:0]            sop_q, sop_d;
   logic [4:0]            srd_q, srd_d;

   assign is_shift = (Operation == 4'b0100) || (Operation == 4'b0101) ||
                     (Operation == 4'b0111);
`endif

   always_comb begin
      diff     = SrcA - SrcB;
      lt       = $signed(SrcA) < $signed(SrcB);
      shamt    = SrcB[4:0];
      alu_res  = '0;
      alu_zero = 1'b0;
      case (Operation)
         4'b0000: alu_res = SrcA & SrcB;
         4'b0001: alu_res = SrcA | SrcB;
         4'b0010: alu_res = SrcA + SrcB;
         4'b0011: alu_res = SrcA ^ SrcB;
         4'b0110: alu_res = diff;
         4'b0100: alu_res = SrcA << shamt;
         4'b0101: alu_res = SrcA >> shamt;
         4'b0111: alu_res = DATA_WIDTH'($signed(SrcA) >>> shamt);
         // 1100 is shared by SLT and BLT: the flag and the 0/1 result agree.
         4'b1100: begin
            alu_res  = {{(DATA_WIDTH-1){1'b0}}, lt};
            alu_zero = lt;
         end
         4'b1000: begin alu_res = diff; alu_zero = (SrcA == SrcB); end
         4'b1010: begin alu_res = diff; alu_zero = (SrcA != SrcB); end
         4'b1001: begin alu_res = diff; alu_zero = !lt; end
         default: begin alu_res = '0; alu_zero = 1'b0; end
      endcase
   end

   always_comb begin
      out_free     = !out_valid_q || out_ready;
      in_ready_int = (state_q == IDLE) && out_free && !flush;
      accept       = in_valid && in_ready_int;

      state_d     = state_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      zero_d      = zero_q;
      rd_d        = rd_q;
`ifdef SERIAL_SHIFT_EN
      cnt_d = cnt_q;
      acc_d = acc_q;
      sop_d = sop_q;
      srd_d = srd_q;
`endif

      if (out_valid_q && out_ready) out_valid_d = 1'b0;

`ifdef SERIAL_SHIFT_EN
      if (accept && is_shift) begin
         state_d = SHIFT;
         cnt_d   = SrcB[4:0];
         acc_d   = SrcA;
         sop_d   = Operation[1:0];
         srd_d   = rd_in;
      end else if (accept) begin
         out_valid_d = 1'b1;
         result_d    = alu_res;
         zero_d      = alu_zero;
         rd_d        = rd_in;
      end

      if (state_q == SHIFT) begin
         if (cnt_q != 5'd0) begin
            cnt_d = cnt_q - 5'd1;
            case (sop_q)
               2'b00:   acc_d = acc_q << 1;
               2'b01:   acc_d = acc_q >> 1;
               default: acc_d = {acc_q[DATA_WIDTH-1], acc_q[DATA_WIDTH-1:1]};
            endcase
         end else if (out_free) begin
            // Counter parked at 0 until the output register can take the result.
            out_valid_d = 1'b1;
            result_d    = acc_q;
            zero_d      = 1'b0;
            rd_d        = srd_q;
            state_d     = IDLE;
         end
      end
`else
      if (accept) begin
         out_valid_d = 1'b1;
         result_d    = alu_res;
         zero_d      = alu_zero;
         rd_d        = rd_in;
      end
`endif

      if (flush) begin
         out_valid_d = 1'b0;
         state_d     = IDLE;
`ifdef SERIAL_SHIFT_EN
         cnt_d = 5'd0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         rd_q        <= 5'd0;
`ifdef SERIAL_SHIFT_EN
         cnt_q <= 5'd0;
         acc_q <= '0;
         sop_q <= 2'b00;
         srd_q <= 5'd0;
`endif
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         rd_q        <= rd_d;
`ifdef SERIAL_SHIFT_EN
         cnt_q <= cnt_d;
         acc_q <= acc_d;
         sop_q <= sop_d;
         srd_q <= srd_d;
`endif
      end
   end

   // Gated with rst_n so the stage never advertises space while held in reset.
   assign in_ready  = in_ready_int && rst_n;
   assign out_valid = out_valid_q;
   assign ALUResult = result_q;
   assign Zero      = zero_q;
   assign rd_out    = rd_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage; follows SERIAL_SHIFT_EN for shift latency.
module tb_alu_exec_stage;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [3:0]    Operation = 4'd0;
   logic [DW-1:0] SrcA = '0;
   logic [DW-1:0] SrcB = '0;
   logic [4:0]    rd_in = 5'd0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] ALUResult;
   logic          Zero;
   logic [4:0]    rd_out;

   int vectors = 0;
   int miscompares = 0;
   int cycle = 0;
   bit rand_ready = 1'b0;
   logic [DW+5:0] exp_q[$];

`ifdef SERIAL_SHIFT_EN
   localparam bit SERIAL = 1'b1;
`else
   localparam bit SERIAL = 1'b0;
`endif

   alu_exec_stage #(.DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB), .rd_in(rd_in),
      .out_valid(out_valid), .out_ready(out_ready), .ALUResult(ALUResult),
      .Zero(Zero), .rd_out(rd_out)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   // random consumer backpressure, only while enabled
   initial forever begin
      @(posedge clk); #2;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   end

   // reference model: {Zero, ALUResult}
   function automatic logic [DW:0] model(input logic [3:0] op, input logic [DW-1:0] a,
                                         input logic [DW-1:0] b);
      logic signed [DW-1:0] sa, sb;
      sa = a;
      sb = b;
      case (op)
         4'b0000: return {1'b0, a & b};
         4'b0001: return {1'b0, a | b};
         4'b0010: return {1'b0, a + b};
         4'b0011: return {1'b0, a ^ b};
         4'b0110: return {1'b0, a - b};
         4'b0100: return {1'b0, a << b[4:0]};
         4'b0101: return {1'b0, a >> b[4:0]};
         4'b0111: return {1'b0, DW'(sa >>> b[4:0])};
         4'b1100: return (sa < sb) ? {1'b1, DW'(1)} : {1'b0, DW'(0)};
         4'b1000: return {a == b, a - b};
         4'b1010: return {a != b, a - b};
         4'b1001: return {sa >= sb, a - b};
         default: return '0;
      endcase
   endfunction

   // scoreboard: pop on every transfer
   always @(negedge clk) begin
      logic [DW+5:0] e;
      if (rst_n && out_valid && out_ready) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_output got rd=%0d zero=%0b res=%h, none expected",
                     rd_out, Zero, ALUResult);
         end else begin
            e = exp_q.pop_front();
            if ({rd_out, Zero, ALUResult} !== e) begin
               miscompares++;
               $display("FAIL result got rd=%0d zero=%0b res=%h expected rd=%0d zero=%0b res=%h",
                        rd_out, Zero, ALUResult, e[DW+5:DW+1], e[DW], e[DW-1:0]);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk); #2;
   endtask

   // driver: call at posedge+2, returns at posedge+2 after the accepting edge
   task automatic drive(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [4:0] rd);
      int n = 0;
      Operation = op; SrcA = a; SrcB = b; rd_in = rd; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 300) begin n++; @(negedge clk); end
      if (!in_ready) begin
         vectors++; miscompares++;
         $display("FAIL accept_timeout op=%b in_ready=%b expected 1", op, in_ready);
      end else exp_q.push_back({rd, model(op, a, b)});
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      rand_ready = 1'b0;
      out_ready = 1'b1;
      while ((exp_q.size() != 0 || out_valid) && n < 500) begin n++; step(); end
      if (exp_q.size() != 0 || out_valid) begin
         vectors++; miscompares++;
         $display("FAIL drain_timeout pending=%0d out_valid=%b expected 0/0", exp_q.size(), out_valid);
      end
   endtask

   task automatic test_reset();
      #12;
      vectors++;
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b expected 0", in_ready); end
      step();
      rst_n = 1'b1;
      @(negedge clk);
      vectors += 5;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready got %b expected 1", in_ready); end
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
      if (ALUResult !== '0) begin miscompares++; $display("FAIL reset_result got %h expected 0", ALUResult); end
      if (Zero !== 1'b0) begin miscompares++; $display("FAIL reset_zero got %b expected 0", Zero); end
      if (rd_out !== 5'd0) begin miscompares++; $display("FAIL reset_rd got %0d expected 0", rd_out); end
      step();
   endtask

   task automatic test_basic_ops();
      out_ready = 1'b1;
      drive(4'b0010, 32'd5, 32'd7, 5'd3);
      vectors++;
      if (!(out_valid === 1'b1 && ALUResult === 32'd12 && Zero === 1'b0 && rd_out === 5'd3)) begin
         miscompares++;
         $display("FAIL add_latency got v=%b res=%h z=%b rd=%0d expected 1/0000000c/0/3",
                  out_valid, ALUResult, Zero, rd_out);
      end
      drive(4'b0110, 32'd3, 32'd5, 5'd4);
      drive(4'b1100, 32'hFFFF_FFFF, 32'd1, 5'd5);
      drive(4'b1001, 32'hFFFF_FFFF, 32'd1, 5'd6);
      drive(4'b1000, 32'd9, 32'd9, 5'd7);
      drive(4'b1010, 32'd9, 32'd9, 5'd8);
      drive(4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd9);
      drive(4'b0001, 32'hF000_0000, 32'h0000_000F, 5'd10);
      drive(4'b1111, 32'd1, 32'd2, 5'd11);
      drive(4'b0101, 32'h8000_0000, 32'd31, 5'd12);
      wait_drain();
   endtask

   task automatic test_back_to_back();
      int c0;
      out_ready = 1'b1;
      c0 = cycle;
      for (int i = 0; i < 4; i++) drive(4'b0010, DW'(i), 32'd100, 5'(i + 20));
      vectors++;
      if (cycle - c0 !== 4) begin
         miscompares++;
         $display("FAIL back_to_back got %0d cycles expected 4", cycle - c0);
      end
      wait_drain();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(4'b0011, 32'h0000_F0F0, 32'h0000_0FF0, 5'd13);
      Operation = 4'b0010; SrcA = 32'd1; SrcB = 32'd2; rd_in = 5'd14; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (!(ALUResult === 32'h0000_FF00 && in_ready === 1'b0 && out_valid === 1'b1)) begin
            miscompares++;
            $display("FAIL stall_hold got res=%h in_ready=%b v=%b expected 0000ff00/0/1",
                     ALUResult, in_ready, out_valid);
         end
         step();
      end
      out_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL drain_accept in_ready got %b expected 1", in_ready); end
      else exp_q.push_back({5'd14, 1'b0, 32'd3});
      step();
      in_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (!(out_valid === 1'b1 && ALUResult === 32'd3)) begin
         miscompares++;
         $display("FAIL next_after_stall got v=%b res=%h expected 1/00000003", out_valid, ALUResult);
      end
      wait_drain();
   endtask

   task automatic test_shift_latency();
      int k = 0;
      bit seen = 1'b0, bad_ready = 1'b0;
      int exp_lat = SERIAL ? 6 : 1;
      out_ready = 1'b1;
      drive(4'b0111, 32'h8000_0000, 32'd4, 5'd15);
      while (!seen && k < 50) begin
         @(negedge clk);
         k++;
         if (out_valid) seen = 1'b1;
         else if (in_ready !== 1'b0) bad_ready = 1'b1;
      end
      vectors += 3;
      if (k !== exp_lat) begin miscompares++; $display("FAIL sra_latency got %0d expected %0d", k, exp_lat); end
      if (bad_ready) begin miscompares++; $display("FAIL sra_in_ready got 1 during shift expected 0"); end
      if (ALUResult !== 32'hF800_0000) begin
         miscompares++; $display("FAIL sra_value got %h expected f8000000", ALUResult);
      end
      step();
      wait_drain();
   endtask

   task automatic test_flush();
      bit seen = 1'b0;
      out_ready = 1'b0;
      drive(4'b0100, 32'd1, 32'd31, 5'd16);
      void'(exp_q.pop_back());
      for (int i = 0; i < 8; i++) begin @(negedge clk); if (out_valid) seen = 1'b1; end
      step();
      flush = 1'b1;
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_in_ready got %b expected 0", in_ready); end
      step();
      flush = 1'b0;
      @(negedge clk);
      vectors += 2;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_out_valid got %b expected 0", out_valid); end
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_recover got %b expected 1", in_ready); end
`ifdef SERIAL_SHIFT_EN
      vectors++;
      if (seen) begin miscompares++; $display("FAIL flush_no_output got out_valid=1 expected 0"); end
`endif
      step();
      wait_drain();
   endtask

   task automatic check_reset_outputs(input string tag);
      #1;
      vectors++;
      if ({out_valid, ALUResult, Zero, rd_out, in_ready} !== '0) begin
         miscompares++;
         $display("FAIL %s got v=%b res=%h z=%b rd=%0d rdy=%b expected all 0",
                  tag, out_valid, ALUResult, Zero, rd_out, in_ready);
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      drive(4'b0100, 32'd1, 32'd20, 5'd17);
      step(); step();
      rst_n = 1'b0;
      check_reset_outputs("reset_mid_shift");
      exp_q.delete();
      step();
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (!(in_ready === 1'b1 && out_valid === 1'b0)) begin
         miscompares++; $display("FAIL reset_release got rdy=%b v=%b expected 1/0", in_ready, out_valid);
      end
      step();
      drive(4'b0010, 32'h0000_1234, 32'd1, 5'd31);
      vectors++;
      if (out_valid !== 1'b1) begin miscompares++; $display("FAIL held_before_reset got %b expected 1", out_valid); end
      rst_n = 1'b0;
      check_reset_outputs("reset_while_valid");
      exp_q.delete();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_random();
      logic [3:0] ops[14] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h4, 4'h5, 4'h7,
                              4'hC, 4'h8, 4'hA, 4'h9, 4'hF, 4'hB};
      logic [DW-1:0] edge_vals[4] = '{32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
      logic [DW-1:0] a, b;
      rand_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         a = ($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
         b = ($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
         if ($urandom_range(0, 4) == 0) b = a;
         drive(ops[$urandom_range(0, 13)], a, b, 5'($urandom_range(0, 31)));
      end
      wait_drain();
   endtask

   initial begin
      test_reset();
      test_basic_ops();
      test_back_to_back();
      test_backpressure();
      test_shift_latency();
      test_flush();
      test_random();
      test_reset_mid();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++; $display("FAIL leftover_expected got %0d expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
